load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; width is fixed at 32 bits, and the memory side is word-addressed and word-written.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core requests a memory operation
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- addr  in  32  byte address
- wdata  in  32  store data, taken from the low bits
- rsp_valid  out  1  response pulse
- rsp_err  out  1  request rejected (misaligned or illegal funct3)
- rdata  out  32  load result after extension; 0 for stores and errors
- mem_we  out  1  word write strobe to data memory
- mem_addr  out  32  byte address to data memory, always word-aligned
- mem_wdata  out  32  word written to data memory
- mem_rdata  in  32  combinational read data for mem_addr

Function
REQ-003 SHALL implement an FSM with states IDLE, ACCESS, WRITE and RESP.
REQ-004 SHALL assert req_ready only when the state is IDLE and rst=0.
REQ-005 SHALL accept a request in a cycle T when req_valid=1 and req_ready=1, latching req_we, funct3, addr and wdata; input changes after T SHALL be ignored.
REQ-006 SHALL check the request at acceptance:
- illegal funct3: 011, 110, 111, or funct3[2]=1 with req_we=1
- halfword with addr[0]=1
- word with addr[1:0]≠00
Any of these is an error and SHALL send the FSM IDLE->RESP.
REQ-007 SHALL send every valid request IDLE->ACCESS.
REQ-008 SHALL drive mem_addr = {addr_latched[31:2],2'b00} in ACCESS and WRITE, and 0 otherwise.
REQ-009 For loads and SW, the FSM SHALL go ACCESS->RESP; for SB and SH it SHALL go ACCESS->WRITE->RESP.
REQ-010 RESP->IDLE SHALL always happen after one cycle; rsp_valid SHALL equal 1 exactly in RESP.
REQ-011 Response latency SHALL be:
- errors: rsp_valid at T+1
- loads and SW: rsp_valid at T+2
- SB and SH: rsp_valid at T+3
REQ-012 For a load in ACCESS, the unit SHALL register mem_rdata and hold the extracted result on rdata during RESP:
- LB/LBU: byte lane addr[1:0]
- LH/LHU: halfword lane addr[1]
- LB/LH: sign-extend from bit 7/15
- LBU/LHU: zero-extend
- LW: word unchanged
REQ-013 For SW in ACCESS, the unit SHALL assert mem_we=1 with mem_wdata=wdata_latched.
REQ-014 For SB/SH in ACCESS, the unit SHALL keep mem_we=0, read mem_rdata, and register the merged word:
- SB: byte lane addr[1:0] replaced by wdata[7:0]
- SH: halfword lane addr[1] replaced by wdata[15:0]
- all other bits kept
REQ-015 For SB/SH in WRITE, the unit SHALL assert mem_we=1 with mem_wdata equal to the merged word.
REQ-016 Each accepted store SHALL produce exactly one mem_we cycle; loads and errors SHALL produce none.
REQ-017 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-018 In RESP, rsp_err SHALL be 1 for errors and 0 otherwise; rsp_err SHALL be 0 outside RESP.
REQ-019 rdata SHALL be 0 outside RESP and for stores and errors.

Reset
REQ-020 With rst=1 at an edge, state SHALL become IDLE and all latched fields and the registered data SHALL become 0.
REQ-021 In any cycle with rst=1, mem_we, rsp_valid, rsp_err and req_ready SHALL be 0 combinationally; a write in progress SHALL be aborted with memory unchanged.
REQ-022 In the first cycle after rst falls, the unit SHALL be in IDLE with req_ready=1, rsp_valid=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata=0.

Verification
REQ-023 SW, addr 0x0000_0010, wdata 0xDEAD_BEEF, accepted at T -> at T+1 mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF; rsp_valid=1 at T+2 only; the memory word reads back 0xDEAD_BEEF.
REQ-024 Memory word 0x10 = 0x8765_43F1:
- LB 0x10 -> rdata 0xFFFF_FFF1
- LBU 0x11 -> 0x0000_0043
- LH 0x12 -> 0xFFFF_8765
- LHU 0x12 -> 0x0000_8765
- LW 0x10 -> 0x8765_43F1
Each result is valid at T+2 and no mem_we occurs.
REQ-025 Same word, SB 0x13 with wdata 0x1234_56AA -> mem_we=0 at T+1; mem_we=1 at T+2 with mem_wdata 0xAA65_43F1; rsp_valid at T+3. SH 0x10 with wdata 0x0000_BEEF then writes 0xAA65_BEEF.
REQ-026 LW 0x06, SH 0x11 and funct3=011 -> each gives rsp_valid=1, rsp_err=1, rdata=0 at T+1 and never asserts mem_we.
REQ-027 SH accepted at T with rst=1 during T+2 (WRITE) -> mem_we=0 in T+2, the memory word is unchanged, and req_ready=1 in the cycle after rst falls.
REQ-028 req_valid held high across two LW requests -> req_ready=0 during T+1..T+2, the second request is accepted at T+3, and two separate one-cycle rsp_valid pulses occur at T+2 and T+5.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/halfword/word loads with extension, and sub-word
// stores done as read-modify-write against a word-addressed data memory.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;

   logic        accept;
   logic        req_err;
   logic        sub_store;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;
   logic [31:0] merge_val;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign sub_store = we_q && (funct3_q[1:0] != 2'b10);

   // Legality and alignment are judged on the live request at acceptance.
   always_comb begin
      req_err = 1'b0;
      case (funct3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = addr[0];
         3'b010:  req_err = (addr[1:0] != 2'b00);
         3'b100:  req_err = req_we;
         3'b101:  req_err = req_we | addr[0];
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   load_val = {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte};
         2'b01:   load_val = {{16{~funct3_q[2] & rd_half[15]}}, rd_half};
         default: load_val = mem_rdata;
      endcase
      merge_val = mem_rdata;
      if (funct3_q[1:0] == 2'b00)
         merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      err_d    = err_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d     = req_we;
               err_d    = req_err;
               funct3_d = funct3;
               addr_d   = addr;
               wdata_d  = wdata;
               data_d   = 32'd0;
               state_d  = req_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            // Loads capture the extracted value; sub-word stores capture the merged word.
            if (!we_q)
               data_d = load_val;
            else if (sub_store)
               data_d = merge_val;
            state_d = sub_store ? WRITE : RESP;
         end
         WRITE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         data_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         err_q    <= err_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         data_q   <= data_d;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rdata     = 32'd0;
      if (state_q == ACCESS || state_q == WRITE)
         mem_addr = {addr_q[31:2], 2'b00};
      if (!rst) begin
         if (state_q == ACCESS && we_q && !sub_store) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
         end else if (state_q == WRITE) begin
            mem_we    = 1'b1;
            mem_wdata = data_q;
         end
         if (state_q == RESP) begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!we_q && !err_q)
               rdata = data_q;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a response scoreboard and a
// behavioural word memory; hand sequences cover reset abort and back-to-back.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] mem_after;
   } vec_t;

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[17];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   we_cnt = 0;

   load_store_unit dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rdata     (rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we)
         mem[mem_addr[7:2]] <= mem_wdata;
   end

   assign mem_rdata = mem[mem_addr[7:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every response is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (mem_we)
            we_cnt++;
         else
            chk("wdata_zero_when_idle", mem_wdata, 32'd0);
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_cycle", cyc, e.cyc);
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               chk("rsp_rdata", rdata, e.rdata);
            end
         end else begin
            chk("quiet_outputs", {rsp_err, rdata[30:0]} | {31'd0, rdata[31]}, 32'd0);
         end
      end
   end

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic err, input logic [31:0] rd,
                        input int lat, input logic push, output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
      end
      req_valid = 1'b1;
      req_we    = we;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      t = cyc;
      if (push)
         sb_q.push_back('{cyc: t + lat, err: err, rdata: rd});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      funct3    = 3'($urandom_range(0, 7));
      addr      = $urandom;
      wdata     = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      int t;
      int w0;
      vecs[0]  = '{1'b1, 3'b010, 32'h04, 32'h0000_0000, 1'b0, 32'h0, 2, 32'h0000_0000};
      vecs[1]  = '{1'b1, 3'b010, 32'h10, 32'h8765_43F1, 1'b0, 32'h0, 2, 32'h8765_43F1};
      vecs[2]  = '{1'b0, 3'b000, 32'h10, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFF1, 2, 32'h8765_43F1};
      vecs[3]  = '{1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h0000_0043, 2, 32'h8765_43F1};
      vecs[4]  = '{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_8765, 2, 32'h8765_43F1};
      vecs[5]  = '{1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_8765, 2, 32'h8765_43F1};
      vecs[6]  = '{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8765_43F1, 2, 32'h8765_43F1};
      vecs[7]  = '{1'b1, 3'b000, 32'h13, 32'h1234_56AA, 1'b0, 32'h0, 3, 32'hAA65_43F1};
      vecs[8]  = '{1'b1, 3'b001, 32'h10, 32'h0000_BEEF, 1'b0, 32'h0, 3, 32'hAA65_BEEF};
      vecs[9]  = '{1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1, 32'h0000_0000};
      vecs[10] = '{1'b1, 3'b001, 32'h11, 32'h0000_1234, 1'b1, 32'h0, 1, 32'hAA65_BEEF};
      vecs[11] = '{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 32'hAA65_BEEF};
      vecs[12] = '{1'b1, 3'b100, 32'h10, 32'h0000_0011, 1'b1, 32'h0, 1, 32'hAA65_BEEF};
      vecs[13] = '{1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFAA, 2, 32'hAA65_BEEF};
      vecs[14] = '{1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'h0000_00EF, 2, 32'hAA65_BEEF};
      vecs[15] = '{1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, 32'hAA65_BEEF};
      vecs[16] = '{1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_BEEF, 2, 32'hAA65_BEEF};

      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      funct3 = 3'd0;
      addr = 32'd0;
      wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_ready_low", {31'd0, req_ready}, 32'd0);
      chk("reset_rsp_low", {30'd0, rsp_valid, mem_we}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
      chk("post_reset_flags", {30'd0, rsp_valid, mem_we}, 32'd0);
      chk("post_reset_mem_addr", mem_addr, 32'd0);
      chk("post_reset_mem_wdata", mem_wdata, 32'd0);
      chk("post_reset_rdata", rdata, 32'd0);

      // SW with the write strobe observed in the ACCESS cycle.
      issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1'b1, t);
      @(negedge clk);
      chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
      chk("sw_mem_addr", mem_addr, 32'h10);
      chk("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      drain();
      chk("sw_readback", mem[4], 32'hDEAD_BEEF);

      for (int i = 0; i < 17; i++) begin
         w0 = we_cnt;
         issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].err,
               vecs[i].rdata, vecs[i].lat, 1'b1, t);
         drain();
         chk($sformatf("vec%0d_we_count", i), we_cnt - w0,
             (vecs[i].we && !vecs[i].err) ? 32'd1 : 32'd0);
         chk($sformatf("vec%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].mem_after);
      end

      // SB: read in ACCESS with no strobe, merged word written in WRITE.
      issue(1'b1, 3'b000, 32'h12, 32'h0000_0055, 1'b0, 32'h0, 3, 1'b1, t);
      @(negedge clk);
      chk("sb_access_no_we", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      chk("sb_write_we", {31'd0, mem_we}, 32'd1);
      chk("sb_write_data", mem_wdata, 32'hAA55_BEEF);
      drain();

      // SH aborted by reset while in WRITE.
      issue(1'b1, 3'b001, 32'h10, 32'h0000_1111, 1'b0, 32'h0, 3, 1'b0, t);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
      chk("abort_ready_low", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
      chk("abort_mem_unchanged", mem[4], 32'hAA55_BEEF);
      repeat (4) @(negedge clk);

      // Two LW requests with req_valid held high throughout.
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      funct3 = 3'b010;
      addr = 32'h10;
      wdata = 32'd0;
      t = cyc;
      sb_q.push_back('{cyc: t + 2, err: 1'b0, rdata: 32'hAA55_BEEF});
      sb_q.push_back('{cyc: t + 5, err: 1'b0, rdata: 32'hAA55_BEEF});
      @(negedge clk);
      chk("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_t2", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_ready_t3", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
